wb_arbiter_2m: RTL and testbench
================================

WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all masters and the slave port.
REQ-002 Parameter DATA_W, default 32, data width; select width is DATA_W/8.
REQ-003 Parameter TIMEOUT_CYC, default 255, cycles without ack before a granted transfer is aborted (8-bit counter, range 1..255).
REQ-004 clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 mN_cyc_i, N=0,1  input  1  master N cycle; acts as the bus request.
REQ-007 mN_stb_i  input  1  master N strobe.
REQ-008 mN_we_i  input  1  master N write enable.
REQ-009 mN_sel_i  input  DATA_W/8  master N byte selects.
REQ-010 mN_addr_i  input  ADDR_W  master N address.
REQ-011 mN_data_i  input  DATA_W  master N write data.
REQ-012 mN_ack_o  output  1  acknowledge to master N.
REQ-013 mN_err_o  output  1  timeout error pulse to master N.
REQ-014 mN_data_o  output  DATA_W  read data to master N.
REQ-015 s_cyc_o, s_stb_o, s_we_o  output  1 each  muxed slave-side controls.
REQ-016 s_sel_o  output  DATA_W/8; s_addr_o  output  ADDR_W; s_data_o  output  DATA_W  muxed slave-side payload.
REQ-017 s_data_i  input  DATA_W; s_ack_i  input  1  slave read data and acknowledge.
REQ-018 grant_o  output  2  one-hot current owner (bit N = master N), 2'b00 when idle.

Function
REQ-019 States IDLE, GNT0, GNT1; registered; grant_o decoded from state.
REQ-020 IDLE: only m0_cyc_i high -> GNT0; only m1_cyc_i high -> GNT1; both high -> the master other than last_owner; neither -> IDLE.
REQ-021 last_owner register updates on every entry to GNT0/GNT1; reset value 1, so m0 wins the first simultaneous request.
REQ-022 Grant latency: one cycle from mN_cyc_i rising in IDLE to grant_o bit N and s_cyc_o high.
REQ-023 GNTn held while mn_cyc_i high; multi-beat transfers are never pre-empted.
REQ-024 GNTn with mn_cyc_i low: other master's cyc high -> go directly to its GNT state (no idle cycle), else IDLE.
REQ-025 Slave outputs are combinational muxes of the granted master's signals; in IDLE s_cyc_o=s_stb_o=s_we_o=0, s_sel_o, s_addr_o, s_data_o =0.
REQ-026 s_cyc_o and s_stb_o are additionally gated by the granted master's live cyc, so a master dropping cyc drops the slave cycle the same cycle.
REQ-027 s_ack_i routed only to the granted master's mN_ack_o; non-granted master's ack is 0 at all times.
REQ-028 s_data_i broadcast unregistered to both mN_data_o.
REQ-029 s_ack_i in IDLE is ignored.

Reset
REQ-030 rst_ni low: state=IDLE, last_owner=1, timeout counter=0, grant_o=0, all mN_ack_o/mN_err_o=0, all s_* outputs 0, asynchronously.
REQ-031 Reset mid-transfer aborts it with no ack or err issued; first arbitration after release follows REQ-020.

Configuration
REQ-032 Macro WB_ARB_TIMEOUT_EN defined: counter clears on grant change or s_ack_i, increments each granted cycle with s_stb_o high and s_ack_i low; on reaching TIMEOUT_CYC, mN_err_o pulses one cycle to the owner, s_cyc_o/s_stb_o forced 0 that cycle, state -> IDLE, last_owner unchanged.
REQ-033 After a timeout, the aborted master must drop and re-raise cyc before re-grant; the other requesting master wins.
REQ-034 Macro undefined: no counter is built, mN_err_o tied 0, grants held indefinitely.

Verification
REQ-035 Reset, then m0 and m1 cyc+stb rise same cycle -> next cycle grant_o=2'b01, s_addr_o=m0_addr_i; m0 read ack with s_data_i=32'hDEADBEEF -> m0_ack_o=1, m1_ack_o=0.
REQ-036 m0 holds cyc for 4 acked beats while m1 requests -> grant_o stays 2'b01; m0 drops cyc -> grant_o=2'b10 next cycle, no IDLE cycle.
REQ-037 Both masters request continuously, each doing single-beat transfers -> grants alternate 01,10,01,10 over 8 transfers.
REQ-038 m1 granted, drops cyc before ack -> s_cyc_o=0 same cycle, late s_ack_i not forwarded, state IDLE next cycle.
REQ-039 WB_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, m0 stb with no slave ack -> m0_err_o pulses exactly 16 granted cycles after grant, grant_o=0 next; unset -> grant holds 100 cycles, m0_err_o=0.
REQ-040 rst_ni asserted mid-transfer -> all outputs 0 immediately, no ack/err pulses.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
`timescale 1ns/1ps
// Two-master Wishbone arbiter: alternates on contention, never pre-empts a held cycle.
// Define WB_ARB_TIMEOUT_EN to abort a granted cycle that waits TIMEOUT_CYC cycles for ack.
module wb_arbiter_2m #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_data_i,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  output logic [DATA_W-1:0]   m0_data_o,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_data_i,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic [DATA_W-1:0]   m1_data_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_data_o,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_ack_i,
  output logic [1:0]          grant_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_e;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must lie in 1..255");
  end

  state_e     state_q, state_d;
  logic       last_owner_q;
  logic       fire;
  logic [1:0] blk;
  logic       req0, req1, g0, g1;

  assign g0   = (state_q == GNT0);
  assign g1   = (state_q == GNT1);
  // A master that timed out may not win again until it has released cyc.
  assign req0 = m0_cyc_i & ~blk[0];
  assign req1 = m1_cyc_i & ~blk[1];

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);
  logic [7:0] cnt_q;
  logic [1:0] blk_q;

  assign fire = (state_q != IDLE) && (cnt_q == TO_LIM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      blk_q <= '0;
    end else begin
      if (state_d != state_q || s_ack_i || state_q == IDLE) cnt_q <= '0;
      else if (s_stb_o)                                      cnt_q <= cnt_q + 8'd1;
      blk_q[0] <= (fire && g0) || (blk_q[0] && m0_cyc_i);
      blk_q[1] <= (fire && g1) || (blk_q[1] && m1_cyc_i);
    end
  end

  assign blk      = blk_q;
  assign m0_err_o = fire && g0;
  assign m1_err_o = fire && g1;
`else
  assign fire     = 1'b0;
  assign blk      = 2'b00;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_d != state_q && state_d == GNT0) last_owner_q <= 1'b0;
      if (state_d != state_q && state_d == GNT1) last_owner_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = last_owner_q ? GNT0 : GNT1;
        else if (req0)    state_d = GNT0;
        else if (req1)    state_d = GNT1;
      end
      GNT0: begin
        if (fire)           state_d = IDLE;
        else if (!m0_cyc_i) state_d = req1 ? GNT1 : IDLE;
      end
      GNT1: begin
        if (fire)           state_d = IDLE;
        else if (!m1_cyc_i) state_d = req0 ? GNT0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Slave side follows the owner; cyc/stb also track the owner's live cyc.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_addr_o = '0;
    s_data_o = '0;
    if (g0) begin
      s_cyc_o  = m0_cyc_i & ~fire;
      s_stb_o  = m0_cyc_i & m0_stb_i & ~fire;
      s_we_o   = m0_we_i;
      s_sel_o  = m0_sel_i;
      s_addr_o = m0_addr_i;
      s_data_o = m0_data_i;
    end else if (g1) begin
      s_cyc_o  = m1_cyc_i & ~fire;
      s_stb_o  = m1_cyc_i & m1_stb_i & ~fire;
      s_we_o   = m1_we_i;
      s_sel_o  = m1_sel_i;
      s_addr_o = m1_addr_i;
      s_data_o = m1_data_i;
    end
  end

  assign m0_ack_o  = g0 & m0_cyc_i & ~fire & s_ack_i;
  assign m1_ack_o  = g1 & m1_cyc_i & ~fire & s_ack_i;
  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;
  assign grant_o   = {g1, g0};
endmodule

// File: tb/tb_wb_arbiter_2m.sv
`timescale 1ns/1ps
// Randomized two-master traffic against a transaction scoreboard and an ownership model,
// followed by directed timeout/hold and mid-transfer reset sequences.
module tb_wb_arbiter_2m;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [3:0]  m0_sel = 0, m1_sel = 0;
  logic [31:0] m0_addr = 0, m0_wdat = 0, m1_addr = 0, m1_wdat = 0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_addr, s_wdat;
  logic [31:0] s_rdat = 0;
  logic        s_ack = 0;
  logic [1:0]  grant;

  wb_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_addr_i(m0_addr), .m0_data_i(m0_wdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m0_data_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_addr_i(m1_addr), .m1_data_i(m1_wdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m1_data_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_addr_o(s_addr), .s_data_o(s_wdat), .s_data_i(s_rdat), .s_ack_i(s_ack),
    .grant_o(grant)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q0[$];
  beat_t exp_q1[$];
  int    alt_seq[$];
  int    checks = 0;
  int    failures = 0;
  int    slave_mode = 3;  // 0 silent, 1 random, 2 always ack, 3 ack stuck high
  bit    model_on = 0;
  bit    alt_on = 0;
  int    owner = -1;
  int    recent = 1;

  function automatic logic [31:0] rd_word(logic [31:0] a);
    return a ^ 32'hDEADBEEF;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic drive(int n, logic cyc, logic stb, logic we, logic [3:0] sel,
                       logic [31:0] addr, logic [31:0] data);
    if (n == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdat = data;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdat = data;
    end
  endtask

  task automatic wait_grant(logic [1:0] g, string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      if (grant === g) seen = 1;
    end
    check(name, seen, 1'b1);
  endtask

  // One master issuing ntx transactions of 1..4 beats; may abandon a beat early.
  task automatic run_master(int n, int ntx, bit single, bit gaps, bit aborts);
    int    gap, beats;
    bit    quit, got;
    beat_t bt;
    for (int t = 0; t < ntx; t++) begin
      gap   = (gaps && t > 0) ? int'($urandom_range(0, 3)) : 0;
      beats = single ? 1 : int'($urandom_range(1, 4));
      quit  = 0;
      repeat (gap) @(posedge clk_i);
      #1;
      for (int b = 0; b < beats && !quit; b++) begin
        got     = 0;
        bt.addr = $urandom;
        bt.we   = 1'($urandom_range(0, 1));
        bt.sel  = 4'($urandom_range(1, 15));
        bt.data = $urandom;
        drive(n, 1'b1, 1'b1, bt.we, bt.sel, bt.addr, bt.data);
        if (n == 0) exp_q0.push_back(bt); else exp_q1.push_back(bt);
        for (int w = 0; w < 300 && !got && !quit; w++) begin
          @(negedge clk_i);
          if ((n == 0 ? m0_ack : m1_ack) === 1'b1) got = 1;
          else if (aborts && $urandom_range(0, 19) == 0) quit = 1;
        end
        if (!got) begin
          if (!quit) check("ack_wait", 1'b0, 1'b1);
          quit = 1;
          if (n == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
        end
        @(posedge clk_i);
        #1;
      end
      drive(n, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(posedge clk_i);
    end
  endtask

  // Slave responder: drives ack/read data mid-cycle once master inputs have settled.
  initial begin
    forever begin
      @(posedge clk_i);
      #3;
      case (slave_mode)
        1:       s_ack = (s_cyc && s_stb) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
        2:       s_ack = s_cyc && s_stb;
        3:       s_ack = 1'b1;
        default: s_ack = 1'b0;
      endcase
      s_rdat = (s_cyc && s_stb) ? rd_word(s_addr) : $urandom;
    end
  end

  // Ownership model: holder keeps the bus while its cyc is high; a freed bus goes to the
  // sole requester, or under contention to the master not served most recently.
  task automatic model_step();
    logic [1:0] cyc, eg;
    logic       oc;
    beat_t      e;
    bit         emp;
    int         nxt;
    cyc = {m1_cyc, m0_cyc};
    eg  = (owner < 0) ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10);
    oc  = (owner < 0) ? 1'b0 : cyc[owner];
    check("grant", grant, eg);
    check("s_cyc", s_cyc, oc);
    check("m0_ack", m0_ack, s_ack && owner == 0 && cyc[0]);
    check("m1_ack", m1_ack, s_ack && owner == 1 && cyc[1]);
    if (oc && s_ack) begin
      emp = (owner == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
      check("sb_underflow", emp, 1'b0);
      if (!emp) begin
        e = (owner == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check("beat_addr", s_addr, e.addr);
        check("beat_we", s_we, e.we);
        check("beat_sel", s_sel, e.sel);
        if (e.we) check("beat_wdata", s_wdat, e.data);
        check("beat_rdata", owner == 0 ? m0_rdat : m1_rdat, rd_word(e.addr));
        check("rdata_bcast", owner == 0 ? m1_rdat : m0_rdat, s_rdat);
      end
      if (alt_on) alt_seq.push_back(owner);
    end
    if (!oc) begin
      if (cyc == 2'b11)  nxt = (recent == 1) ? 0 : 1;
      else if (cyc[0])   nxt = 0;
      else if (cyc[1])   nxt = 1;
      else               nxt = -1;
      if (nxt >= 0) recent = nxt;
      owner = nxt;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (model_on) model_step();
    end
  end

  initial begin
    int n;
    bit seen;
    int bad;
    repeat (3) @(negedge clk_i);
    check("rst_grant", grant, 2'b00);
    check("rst_s_cyc", s_cyc, 1'b0);
    check("rst_s_stb", s_stb, 1'b0);
    check("rst_s_addr", s_addr, 32'h0);
    check("rst_acks", {m0_ack, m1_ack}, 2'b00);
    check("rst_errs", {m0_err, m1_err}, 2'b00);

    @(posedge clk_i); #1;
    slave_mode = 1;
    owner      = -1;
    recent     = 1;
    model_on   = 1;
    rst_ni     = 1'b1;
    fork
      run_master(0, 25, 1'b0, 1'b1, 1'b1);
      run_master(1, 25, 1'b0, 1'b1, 1'b1);
    join

    alt_on     = 1;
    slave_mode = 2;
    fork
      run_master(0, 4, 1'b1, 1'b0, 1'b0);
      run_master(1, 4, 1'b1, 1'b0, 1'b0);
    join
    alt_on = 0;
    repeat (3) @(negedge clk_i);
    check("sb_empty", exp_q0.size() + exp_q1.size(), 0);
    check("alt_count", alt_seq.size(), 8);
    for (int i = 1; i < alt_seq.size(); i++) check("alt_order", alt_seq[i] != alt_seq[i-1], 1'b1);
    model_on   = 0;
    slave_mode = 0;

    @(posedge clk_i); #1;
    drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    wait_grant(2'b01, "to_grant0");
    @(posedge clk_i); #1;
    drive(1, 1'b1, 1'b1, 1'b1, 4'h3, 32'h200, 32'h55);
`ifdef WB_ARB_TIMEOUT_EN
    n = 0; seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk_i);
      n++;
      if (m0_err === 1'b1) seen = 1;
    end
    check("timeout_cycles", n, 16);
    check("timeout_s_cyc", s_cyc, 1'b0);
    check("timeout_m1_err", m1_err, 1'b0);
    @(negedge clk_i);
    check("timeout_idle", grant, 2'b00);
    check("timeout_err_pulse", m0_err, 1'b0);
    @(negedge clk_i);
    check("timeout_other_wins", grant, 2'b10);
    @(posedge clk_i); #1;
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk_i);
    check("timeout_blocked", grant, 2'b00);
    @(posedge clk_i); #1;
    drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk_i); #1;
    drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    check("timeout_regrant", grant, 2'b01);
`else
    bad = 0;
    repeat (100) begin
      @(negedge clk_i);
      if (grant !== 2'b01 || m0_err !== 1'b0 || m1_err !== 1'b0) bad++;
    end
    check("hold_100", bad, 0);
    @(posedge clk_i); #1;
    drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    check("handover_same", grant, 2'b01);
    @(negedge clk_i);
    check("handover_direct", grant, 2'b10);
`endif
    @(posedge clk_i); #1;
    drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk_i);

    #1;
    drive(0, 1'b1, 1'b1, 1'b1, 4'hF, 32'hABC, 32'h1234);
    wait_grant(2'b01, "rst_mid_grant");
    #1;
    rst_ni     = 1'b0;
    slave_mode = 3;
    #1;
    check("rst_mid_grant0", grant, 2'b00);
    check("rst_mid_s_cyc", {s_cyc, s_stb, s_we}, 3'b000);
    check("rst_mid_s_payload", {s_addr, s_wdat}, 64'h0);
    check("rst_mid_ack_err", {m0_ack, m0_err}, 2'b00);
    drive(1, 1'b1, 1'b1, 1'b0, 4'h1, 32'hDEF, 32'h0);
    repeat (2) begin
      @(negedge clk_i);
      check("rst_hold_quiet", {grant, m0_ack, m1_ack, m0_err, m1_err}, 6'h0);
    end
    @(posedge clk_i); #1;
    slave_mode = 0;
    rst_ni     = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("rst_first_arb", grant, 2'b01);
    check("rst_first_addr", s_addr, 32'hABC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
